// File: rtl/mem_access_pkg.sv
// Shared opcodes, bus size codes, FSM state codes and record types for the memory stage.
`default_nettype none

package mem_access_pkg;

   localparam logic [5:0] EXE_LB  = 6'h20;
   localparam logic [5:0] EXE_LH  = 6'h21;
   localparam logic [5:0] EXE_LW  = 6'h23;
   localparam logic [5:0] EXE_LBU = 6'h24;
   localparam logic [5:0] EXE_LHU = 6'h25;
   localparam logic [5:0] EXE_SB  = 6'h28;
   localparam logic [5:0] EXE_SH  = 6'h29;
   localparam logic [5:0] EXE_SW  = 6'h2B;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [1:0] MEM_IDLE = 2'd0;
   localparam logic [1:0] MEM_REQ  = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic        wr;
      logic [31:0] rt;
      logic        reg_write;
      logic [4:0]  write_reg;
      logic [31:0] pc;
   } req_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic        reg_write;
      logic [4:0]  write_reg;
      logic [31:0] pc;
   } wb_t;

   function automatic logic [1:0] op_size(input logic [5:0] op);
      case (op)
         EXE_LB, EXE_LBU, EXE_SB: return SIZE_B;
         EXE_LH, EXE_LHU, EXE_SH: return SIZE_H;
         EXE_LW, EXE_SW:          return SIZE_W;
         default:                 return SIZE_W;
      endcase
   endfunction

   function automatic logic op_unsigned(input logic [5:0] op);
      return (op == EXE_LBU) || (op == EXE_LHU);
   endfunction

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_H:  return ~lo[0];
         SIZE_W:  return lo == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_align.sv
// Store lane replication / byte strobes and load lane extraction with sign or zero extension.
`default_nettype none

module mem_access_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [1:0]  i_lo,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_wstrb   = 4'b1111;
      o_wdata   = i_st_data;
      o_ld_data = i_rdata;
      case (i_size)
         SIZE_B: begin
            o_wstrb   = 4'b0001 << i_lo;
            o_wdata   = {4{i_st_data[7:0]}};
            o_ld_data = {{24{~i_uns & w_byte[7]}}, w_byte};
         end
         SIZE_H: begin
            o_wstrb   = i_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata   = {2{i_st_data[15:0]}};
            o_ld_data = {{16{~i_uns & w_half[15]}}, w_half};
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// Memory stage: split-handshake data-SRAM master, writeback pipeline registers and upstream stall.
`default_nettype none

module mem_access
   import mem_access_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wb_stall,
   input  logic          ex_valid,
   input  logic [31:0]   ex_inst,
   input  logic [31:0]   ex_pc,
   input  logic [31:0]   ex_alu_result,
   input  logic [DW-1:0] ex_mem_data,
   input  logic          ex_mem_read,
   input  logic          ex_mem_write,
   input  logic          ex_reg_write,
   input  logic [4:0]    ex_write_reg,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [3:0]    data_wstrb,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata,
   output logic          mem_stall,
   output logic          addr_err,
   output logic          wb_valid,
   output logic [31:0]   wb_result,
   output logic          wb_reg_write,
   output logic [4:0]    wb_write_reg,
   output logic [31:0]   wb_pc
);

   logic [1:0]  r_state, w_next;
   req_t        w_new, r_req, w_cur;
   wb_t         r_wb, r_hold, w_done_wb;
   logic        r_hold_valid, r_flush_pend, r_addr_err;
   logic        w_memop, w_aligned, w_take, w_issue, w_misalign, w_done, w_kill;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata, w_ld_data;
   logic        w_unused_inst;

   assign w_unused_inst = ^ex_inst[25:0];

   always_comb begin
      w_new.addr      = ex_alu_result;
      w_new.size      = op_size(ex_inst[31:26]);
      w_new.uns       = op_unsigned(ex_inst[31:26]);
      w_new.wr        = ex_mem_write;
      w_new.rt        = ex_mem_data;
      w_new.reg_write = ex_reg_write & ~ex_mem_write;
      w_new.write_reg = ex_write_reg;
      w_new.pc        = ex_pc;
   end

   assign w_memop    = ex_mem_read | ex_mem_write;
   assign w_aligned  = is_aligned(w_new.size, w_new.addr[1:0]);
   assign w_take     = (r_state == MEM_IDLE) & ex_valid & ~flush & ~wb_stall & ~r_hold_valid;
   assign w_issue    = w_take & w_memop & w_aligned;
   assign w_misalign = w_take & w_memop & ~w_aligned;
   // In IDLE the request is presented straight from ex_*; afterwards from the captured copy.
   assign w_cur      = (r_state == MEM_IDLE) ? w_new : r_req;
   assign w_kill     = flush | r_flush_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= MEM_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MEM_IDLE: if (w_issue) w_next = data_addr_ok ? (data_data_ok ? MEM_IDLE : MEM_WAIT) : MEM_REQ;
         MEM_REQ:  if (data_addr_ok) w_next = data_data_ok ? MEM_IDLE : MEM_WAIT;
         MEM_WAIT: if (data_data_ok) w_next = MEM_IDLE;
         default:  w_next = MEM_IDLE;
      endcase
   end

   // Stall is released in the completion cycle so the same instruction is never issued twice.
   always_comb begin
      data_req  = w_issue | (r_state == MEM_REQ);
      w_done    = ((w_issue | (r_state == MEM_REQ)) & data_addr_ok & data_data_ok)
                | ((r_state == MEM_WAIT) & data_data_ok);
      mem_stall = ((((r_state == MEM_IDLE) & ex_valid & w_memop & w_aligned & ~flush)
                  | (r_state == MEM_REQ) | (r_state == MEM_WAIT)) & ~w_done)
                | r_hold_valid;
   end

   mem_access_align u_align (
      .i_size    (w_cur.size),
      .i_uns     (w_cur.uns),
      .i_lo      (w_cur.addr[1:0]),
      .i_st_data (w_cur.rt),
      .i_rdata   (data_rdata),
      .o_wstrb   (w_wstrb),
      .o_wdata   (w_wdata),
      .o_ld_data (w_ld_data)
   );

   assign data_wr    = data_req & w_cur.wr;
   assign data_size  = data_req ? w_cur.size : 2'd0;
   assign data_addr  = data_req ? w_cur.addr[AW-1:0] : '0;
   assign data_wstrb = data_wr ? w_wstrb : 4'd0;
   assign data_wdata = data_wr ? w_wdata : '0;

   always_comb begin
      w_done_wb.valid     = ~w_kill;
      w_done_wb.result    = w_cur.wr ? w_cur.addr : w_ld_data;
      w_done_wb.reg_write = w_cur.reg_write;
      w_done_wb.write_reg = w_cur.write_reg;
      w_done_wb.pc        = w_cur.pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req        <= '0;
         r_wb         <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_flush_pend <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         r_addr_err <= w_misalign;
         if (w_issue) r_req <= w_new;

         if (w_done)
            r_flush_pend <= 1'b0;
         else if (flush && r_state != MEM_IDLE)
            r_flush_pend <= 1'b1;

         if (wb_stall) begin
            if (w_done && !w_kill) begin
               r_hold       <= w_done_wb;
               r_hold_valid <= 1'b1;
            end
         end else if (r_hold_valid) begin
            r_wb         <= r_hold;
            r_hold_valid <= 1'b0;
         end else if (w_done) begin
            r_wb <= w_done_wb;
         end else begin
            r_wb.valid     <= w_take & ~(w_memop & w_aligned);
            r_wb.result    <= ex_alu_result;
            r_wb.reg_write <= ex_reg_write & ~w_memop;
            r_wb.write_reg <= ex_write_reg;
            r_wb.pc        <= ex_pc;
         end
      end
   end

   assign addr_err     = r_addr_err;
   assign wb_valid     = r_wb.valid;
   assign wb_result    = r_wb.result;
   assign wb_reg_write = r_wb.reg_write;
   assign wb_write_reg = r_wb.write_reg;
   assign wb_pc        = r_wb.pc;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; writeback results are checked against a queue of expected records.
`default_nettype none

module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst, flush, wb_stall, ex_valid;
   logic [31:0] ex_inst, ex_pc, ex_alu_result, ex_mem_data;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;
   logic [4:0]  ex_write_reg;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_stall, addr_err, wb_valid, wb_reg_write;
   logic [31:0] wb_result, wb_pc;
   logic [4:0]  wb_write_reg;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] pc;
      bit          chk_res;
   } exp_t;
   exp_t q[$];

   mem_access dut (
      .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall),
      .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
      .ex_alu_result(ex_alu_result), .ex_mem_data(ex_mem_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_stall(mem_stall), .addr_err(addr_err),
      .wb_valid(wb_valid), .wb_result(wb_result), .wb_reg_write(wb_reg_write),
      .wb_write_reg(wb_write_reg), .wb_pc(wb_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every consumed writeback record must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && wb_valid && !wb_stall) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got pc 0x%08h result 0x%08h expected no record", wb_pc, wb_result);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_res) chk("wb_result", wb_result, e.res);
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
            chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, e.wr});
            chk("wb_pc", wb_pc, e.pc);
         end
      end
   end

   task automatic set_ex(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                         input logic rd_en, input logic wr_en, input logic regw,
                         input logic [4:0] rd, input logic [31:0] pc);
      ex_valid      = 1'b1;
      ex_inst       = {op, 26'h0};
      ex_alu_result = alu;
      ex_mem_data   = rt;
      ex_mem_read   = rd_en;
      ex_mem_write  = wr_en;
      ex_reg_write  = regw;
      ex_write_reg  = rd;
      ex_pc         = pc;
   endtask

   task automatic push_exp(input logic [31:0] res, input logic rw, input logic [4:0] wr,
                           input logic [31:0] pc, input bit cr);
      exp_t e;
      e.res = res; e.rw = rw; e.wr = wr; e.pc = pc; e.chk_res = cr;
      q.push_back(e);
   endtask

   // One bus transaction; cycle k = 0 is the issue cycle, addr_ok at a_dly, data_ok at d_dly.
   task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input int a_dly, input int d_dly,
                         input int flush_k, input int stall_k, input logic is_st,
                         input logic [1:0] e_size, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_res,
                         input logic [4:0] rd, input logic [31:0] pc);
      set_ex(op, addr, rt, ~is_st, is_st, ~is_st, rd, pc);
      if (flush_k < 0) push_exp(e_res, ~is_st, rd, pc, !is_st);
      for (int k = 0; k <= d_dly; k++) begin
         data_addr_ok = (k == a_dly);
         data_data_ok = (k == d_dly);
         data_rdata   = rdata;
         flush        = (k == flush_k);
         if (k == flush_k) ex_valid = 1'b0;
         wb_stall     = (k == stall_k);
         @(negedge clk);
         chk("data_req", {31'd0, data_req}, {31'd0, k <= a_dly});
         chk("mem_stall", {31'd0, mem_stall}, {31'd0, k < d_dly});
         if (k <= a_dly) begin
            chk("data_addr", data_addr, addr);
            chk("data_size", {30'd0, data_size}, {30'd0, e_size});
            chk("data_wr", {31'd0, data_wr}, {31'd0, is_st});
            if (is_st) begin
               chk("data_wstrb", {28'd0, data_wstrb}, {28'd0, e_strb});
               chk("data_wdata", data_wdata, e_wdata);
            end
         end
         step();
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0; wb_stall = 1'b0; ex_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("req_quiet", {31'd0, data_req}, 32'd0);
         if (flush_k >= 0) chk("flush_discard_wb", {31'd0, wb_valid}, 32'd0);
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; wb_stall = 1'b0; ex_valid = 1'b0;
      ex_inst = '0; ex_pc = '0; ex_alu_result = '0; ex_mem_data = '0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_write_reg = '0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_data_req", {31'd0, data_req}, 32'd0);
      chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // ALU passthrough
      set_ex(6'h00, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h100);
      push_exp(32'h1234, 1'b1, 5'd5, 32'h100, 1'b1);
      @(negedge clk);
      chk("alu_data_req", {31'd0, data_req}, 32'd0);
      chk("alu_mem_stall", {31'd0, mem_stall}, 32'd0);
      step();
      ex_valid = 1'b0;
      step();

      // Flushed ALU op in IDLE produces nothing
      set_ex(6'h00, 32'h5555, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h104);
      flush = 1'b1;
      step();
      flush = 1'b0; ex_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle_wb", {31'd0, wb_valid}, 32'd0);
      step();

      //     op       addr          rt            rdata        a  d  fl  st  st?  size  strb     wdata          result         rd     pc
      mem_op(6'h28, 32'h1003, 32'hAABBCCDD, 32'h0,        1, 2, -1, -1, 1'b1, 2'd0, 4'b1000, 32'hDDDDDDDD, 32'h0,        5'd0,  32'h200);
      mem_op(6'h29, 32'h1002, 32'h11223344, 32'h0,        1, 2, -1, -1, 1'b1, 2'd1, 4'b1100, 32'h33443344, 32'h0,        5'd0,  32'h204);
      mem_op(6'h2B, 32'h1000, 32'h89ABCDEF, 32'h0,        1, 3, -1, -1, 1'b1, 2'd2, 4'b1111, 32'h89ABCDEF, 32'h0,        5'd0,  32'h208);
      mem_op(6'h20, 32'h2001, 32'h0,        32'h00008000, 2, 3, -1, -1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF80, 5'd7,  32'h20C);
      mem_op(6'h24, 32'h2001, 32'h0,        32'h00008000, 2, 3, -1, -1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h00000080, 5'd8,  32'h210);
      mem_op(6'h21, 32'h2002, 32'h0,        32'h80010000, 1, 2, -1, -1, 1'b0, 2'd1, 4'b0000, 32'h0,        32'hFFFF8001, 5'd9,  32'h214);
      mem_op(6'h25, 32'h2000, 32'h0,        32'h1234ABCD, 1, 2, -1, -1, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h0000ABCD, 5'd10, 32'h218);
      mem_op(6'h23, 32'h2004, 32'h0,        32'hCAFEF00D, 1, 2, -1, -1, 1'b0, 2'd2, 4'b0000, 32'h0,        32'hCAFEF00D, 5'd11, 32'h21C);
      // data_ok while writeback is stalled: result must survive in the holding register
      mem_op(6'h23, 32'h3000, 32'h0,        32'h87654321, 1, 2, -1,  2, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h87654321, 5'd12, 32'h220);
      // flush in WAIT: transaction completes on the bus, result discarded
      mem_op(6'h23, 32'h2008, 32'h0,        32'h01010101, 1, 4,  2, -1, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h0,        5'd13, 32'h224);

      // Misaligned word load
      set_ex(6'h23, 32'h2002, 32'h0, 1'b1, 1'b0, 1'b1, 5'd14, 32'h228);
      push_exp(32'h0, 1'b0, 5'd14, 32'h228, 1'b0);
      @(negedge clk);
      chk("mis_data_req", {31'd0, data_req}, 32'd0);
      chk("mis_mem_stall", {31'd0, mem_stall}, 32'd0);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
      chk("mis_data_req2", {31'd0, data_req}, 32'd0);
      step();
      @(negedge clk);
      chk("mis_addr_err_pulse", {31'd0, addr_err}, 32'd0);
      step();

      // Asynchronous reset while a request is outstanding
      set_ex(6'h23, 32'h200C, 32'h0, 1'b1, 1'b0, 1'b1, 5'd15, 32'h22C);
      @(negedge clk);
      chk("rstreq_issue", {31'd0, data_req}, 32'd1);
      step();
      @(negedge clk);
      chk("rstreq_held", {31'd0, data_req}, 32'd1);
      #1;
      rst = 1'b1; ex_valid = 1'b0;
      #1;
      chk("rstreq_data_req", {31'd0, data_req}, 32'd0);
      chk("rstreq_mem_stall", {31'd0, mem_stall}, 32'd0);
      chk("rstreq_wb_valid", {31'd0, wb_valid}, 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", {31'd0, data_req}, 32'd0);
         step();
      end

      chk("queue_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
